// File: rtl/shift_pkg.sv
// Shared types and helpers for the sequential multi-mode shifter.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_LSL   = 3'b000,
    MODE_LSR   = 3'b001,
    MODE_ASR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_PASS5 = 3'b101,
    MODE_PASS6 = 3'b110,
    MODE_PASS7 = 3'b111
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } fsm_state_e;

  function automatic int unsigned clamp_amount(input int unsigned amount, input int unsigned width);
    return (amount > width) ? width : amount;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by n bits (0..STEP) in the
// requested mode and reports the last bit shifted out or wrapped.
module shift_step
  import shift_pkg::*;
#(
  parameter int W    = 8,
  parameter int STEP = 1,
  parameter int NW   = $clog2(STEP + 1)
) (
  input  logic [W-1:0]  value,
  input  shift_mode_e   mode,
  input  logic [NW-1:0] n,
  output logic [W-1:0]  shifted,
  output logic          carry
);

  logic [W:0]    left_ext;
  logic [W:0]    right_ext;
  logic [W:0]    arith_ext;
  logic [W-1:0]  wrap_left;
  logic [W-1:0]  wrap_right;
  logic [31:0]   back;

  // One extra guard bit on each side captures the last bit out; n=0 leaves it 0.
  always_comb begin
    back       = 32'(W) - 32'(n);
    left_ext   = {1'b0, value} << n;
    right_ext  = {value, 1'b0} >> n;
    arith_ext  = $signed({value, 1'b0}) >>> n;
    wrap_left  = value >> back;
    wrap_right = value << back;
    shifted    = value;
    carry      = 1'b0;
    case (mode)
      MODE_LSL: begin
        shifted = left_ext[W-1:0];
        carry   = left_ext[W];
      end
      MODE_LSR: begin
        shifted = right_ext[W:1];
        carry   = right_ext[0];
      end
      MODE_ASR: begin
        shifted = arith_ext[W:1];
        carry   = arith_ext[0];
      end
      MODE_ROL: begin
        shifted = left_ext[W-1:0] | wrap_left;
        carry   = left_ext[W];
      end
      MODE_ROR: begin
        shifted = right_ext[W:1] | wrap_right;
        carry   = right_ext[0];
      end
      default: begin
        shifted = value;
        carry   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_multimode_shifter.sv
// Sequential multi-mode shifter: captures an operation on start and shifts
// STEP bits per enabled cycle, pulsing done when the amount is consumed.
module seq_multimode_shifter
  import shift_pkg::*;
#(
  parameter int W    = 8,
  parameter int STEP = 1,
  parameter int AW   = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amount,
  input  logic [W-1:0]  data_in,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          carry_out,
  output logic          zero
);

  localparam int NW = $clog2(STEP + 1);

  fsm_state_e    state;
  shift_mode_e   mode_q;
  logic [AW-1:0] rem;
  logic [AW-1:0] rem_clamped;
  logic [AW-1:0] rem_next;
  logic [NW-1:0] n_step;
  logic [W-1:0]  shifted;
  logic          step_carry;

  // The final step may be shorter than STEP when the amount is not a multiple of it.
  always_comb begin
    rem_clamped = AW'(clamp_amount(32'(amount), W));
    n_step      = (rem < AW'(STEP)) ? NW'(rem) : NW'(STEP);
    rem_next    = rem - AW'(n_step);
  end

  shift_step #(
    .W    (W),
    .STEP (STEP)
  ) u_step (
    .value   (result),
    .mode    (mode_q),
    .n       (n_step),
    .shifted (shifted),
    .carry   (step_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode_q    <= MODE_LSL;
      rem       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            result    <= data_in;
            zero      <= (data_in == '0);
            carry_out <= 1'b0;
            mode_q    <= shift_mode_e'(mode);
            rem       <= rem_clamped;
            // A zero amount skips SHIFT entirely and reports on the next cycle.
            if (rem_clamped != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          result    <= shifted;
          zero      <= (shifted == '0);
          carry_out <= step_carry;
          rem       <= rem_next;
          if (rem_next == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multimode_shifter.sv
// Self-checking bench: two shifter instances (STEP=1 and STEP=4) driven with
// identical operations and compared against a bit-at-a-time reference model.
module tb_seq_multimode_shifter;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amount;
  logic [W-1:0]  data_in;

  logic          busy1, done1, carry1, zero1;
  logic [W-1:0]  result1;
  logic          busy4, done4, carry4, zero4;
  logic [W-1:0]  result4;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_multimode_shifter #(.W(W), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode),
    .amount(amount), .data_in(data_in), .busy(busy1), .done(done1),
    .result(result1), .carry_out(carry1), .zero(zero1)
  );

  seq_multimode_shifter #(.W(W), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode),
    .amount(amount), .data_in(data_in), .busy(busy4), .done(done4),
    .result(result4), .carry_out(carry4), .zero(zero4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: shift one bit at a time, remembering the bit that fell off.
  task automatic model(input logic [2:0] m, input logic [3:0] amt, input logic [7:0] d,
                       output logic [7:0] r, output logic c, output int a);
    a = (amt > 4'd8) ? 8 : int'(amt);
    r = d;
    c = 1'b0;
    if (m <= 3'd4) begin
      for (int i = 0; i < a; i++) begin
        case (m)
          3'd0: begin c = r[7]; r = {r[6:0], 1'b0}; end
          3'd1: begin c = r[0]; r = {1'b0, r[7:1]}; end
          3'd2: begin c = r[0]; r = {r[7], r[7:1]}; end
          3'd3: begin c = r[7]; r = {r[6:0], r[7]}; end
          default: begin c = r[0]; r = {r[0], r[7:1]}; end
        endcase
      end
    end
  endtask

  task automatic checkSample(input string id, input logic b, input logic d, input logic [7:0] r,
                             input logic c, input logic z, input int e, input int lat,
                             input logic [7:0] er, input logic ec);
    checkOutput({id, ".busy"}, 32'(b), 32'(e < lat));
    checkOutput({id, ".done"}, 32'(d), 32'(e == lat));
    if (e >= lat) begin
      checkOutput({id, ".result"}, 32'(r), 32'(er));
      checkOutput({id, ".carry"}, 32'(c), 32'(ec));
      checkOutput({id, ".zero"}, 32'(z), 32'(er == 8'h00));
    end
  endtask

  // Runs one operation; stall_at freezes en for 3 cycles, glitch_at pulses start mid-shift.
  task automatic applyStimulus(input logic [2:0] m, input logic [3:0] amt, input logic [7:0] d,
                               input int stall_at, input int glitch_at);
    logic [7:0] er;
    logic       ec;
    int         a, lat1, lat4, maxlat, e;
    bit         en_edge, finished;
    model(m, amt, d, er, ec, a);
    lat1     = a;
    lat4     = (a + 3) / 4;
    maxlat   = (lat1 > lat4) ? lat1 : lat4;
    e        = 0;
    en_edge  = 1'b1;
    finished = 1'b0;
    @(negedge clk);
    en = 1'b1; start = 1'b1; mode = m; amount = amt; data_in = d;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (w > 0 && en_edge) e++;
      start   = 1'b0;
      mode    = 3'($urandom);
      amount  = 4'($urandom);
      data_in = 8'($urandom);
      checkSample("s1", busy1, done1, result1, carry1, zero1, e, lat1, er, ec);
      checkSample("s4", busy4, done4, result4, carry4, zero4, e, lat4, er, ec);
      if (e > maxlat) begin
        finished = 1'b1;
        break;
      end
      en      = !(stall_at >= 0 && w >= stall_at && w < stall_at + 3);
      en_edge = en;
      start   = (w == glitch_at);
    end
    en = 1'b1;
    checkOutput("op_complete", 32'(finished), 32'd1);
  endtask

  initial begin
    logic [2:0] rm;
    logic [3:0] ramt;
    logic [7:0] rd;
    int         stall, glitch, ra;

    rst = 1'b0; en = 1'b0; start = 1'b0; mode = '0; amount = '0; data_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst.result", 32'(result1), 32'h00);
    checkOutput("rst.carry", 32'(carry1), 32'd0);
    checkOutput("rst.zero", 32'(zero1), 32'd1);
    checkOutput("rst.busy", 32'(busy1), 32'd0);
    checkOutput("rst.done", 32'(done4), 32'd0);
    rst = 1'b1; en = 1'b1;

    applyStimulus(3'd0, 4'd1,  8'h81, -1, -1);
    applyStimulus(3'd2, 4'd3,  8'h90, -1, -1);
    applyStimulus(3'd3, 4'd1,  8'h80, -1, -1);
    applyStimulus(3'd1, 4'd6,  8'hF0, -1, -1);
    applyStimulus(3'd0, 4'd15, 8'hFF, -1, -1);
    applyStimulus(3'd0, 4'd0,  8'h00, -1, -1);
    applyStimulus(3'd1, 4'd6,  8'hF0, -1,  0);
    applyStimulus(3'd4, 4'd7,  8'hA5,  1, -1);
    applyStimulus(3'd5, 4'd4,  8'h3C, -1, -1);
    applyStimulus(3'd3, 4'd8,  8'h5A, -1, -1);
    applyStimulus(3'd2, 4'd9,  8'h81, -1, -1);

    // Reset in the middle of a shift must abort with no done pulse.
    @(negedge clk);
    start = 1'b1; mode = 3'd0; amount = 4'd8; data_in = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst.busy", 32'(busy1), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("arst.result1", 32'(result1), 32'h00);
    checkOutput("arst.zero1", 32'(zero1), 32'd1);
    checkOutput("arst.busy1", 32'(busy1), 32'd0);
    checkOutput("arst.carry4", 32'(carry4), 32'd0);
    checkOutput("arst.result4", 32'(result4), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("post_rst.done1", 32'(done1), 32'd0);
      checkOutput("post_rst.done4", 32'(done4), 32'd0);
      checkOutput("post_rst.busy1", 32'(busy1), 32'd0);
    end
    applyStimulus(3'd1, 4'd5, 8'hC3, -1, -1);

    for (int i = 0; i < 40; i++) begin
      rm     = 3'($urandom_range(0, 7));
      ramt   = 4'($urandom_range(0, 15));
      rd     = 8'($urandom);
      ra     = (ramt > 4'd8) ? 8 : int'(ramt);
      stall  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      glitch = (ra >= 1 && $urandom_range(0, 1) == 1) ? 0 : -1;
      applyStimulus(rm, ramt, rd, stall, glitch);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
